// File: rtl/pacman_move_controller.sv
// Pacman per-tick movement sequencer.
// On each accepted move_tick it snapshots the current coordinates and first queries
// the maze tile store for the cell in the requested direction. If that cell is a
// wall, it queries the cell along the current heading instead. An open cell is
// committed back to the coordinate register.
// Ports:
//   clock_50, reset_n              clock, asynchronous active-low reset
//   move_tick                      one-cycle movement strobe (accepted only in IDLE)
//   dir_valid, dir_code            requested direction (0 up, 1 down, 2 left, 3 right)
//   pac_x, pac_y                   current position from the coordinate register
//   reg_x_in, reg_y_in, reg_en,
//   reg_readwrite                  coordinate register write port (readwrite 0 = write)
//   tile_req, tile_x, tile_y,
//   tile_ack, tile_type            tile store query handshake
//   pellet_eaten, power_eaten,
//   tile_timeout                   one-cycle event pulses
//   busy, moving, cur_dir          status
module pacman_move_controller #(
    parameter int unsigned GRID_W      = 21,
    parameter int unsigned GRID_H      = 21,
    parameter bit          WRAP_EN     = 1'b1,
    parameter logic [2:0]  WALL_TYPE   = 3'd1,
    parameter logic [2:0]  PELLET_TYPE = 3'd2,
    parameter logic [2:0]  POWER_TYPE  = 3'd3,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       move_tick,
    input  logic       dir_valid,
    input  logic [1:0] dir_code,
    input  logic [4:0] pac_x,
    input  logic [4:0] pac_y,
    output logic [4:0] reg_x_in,
    output logic [4:0] reg_y_in,
    output logic       reg_en,
    output logic       reg_readwrite,
    output logic       tile_req,
    output logic [4:0] tile_x,
    output logic [4:0] tile_y,
    input  logic       tile_ack,
    input  logic [2:0] tile_type,
    output logic       pellet_eaten,
    output logic       power_eaten,
    output logic       tile_timeout,
    output logic       busy,
    output logic       moving,
    output logic [1:0] cur_dir
);

    localparam int unsigned CW     = 8;
    localparam logic [4:0]  LAST_X = 5'(GRID_W - 1);
    localparam logic [4:0]  LAST_Y = 5'(GRID_H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUERY_A = 2'd1,
        S_QUERY_B = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    // One step from (x,y) in direction d; result is {off_grid, nx, ny}.
    function automatic logic [10:0] f_step(input logic [4:0] x, input logic [4:0] y,
                                           input logic [1:0] d);
        logic [4:0] nx;
        logic [4:0] ny;
        logic       off;
        nx  = x;
        ny  = y;
        off = 1'b0;
        case (d)
            2'd0: if (y == 5'd0) begin
                      if (WRAP_EN) ny = LAST_Y; else off = 1'b1;
                  end else ny = y - 5'd1;
            2'd1: if (y == LAST_Y) begin
                      if (WRAP_EN) ny = 5'd0; else off = 1'b1;
                  end else ny = y + 5'd1;
            2'd2: if (x == 5'd0) begin
                      if (WRAP_EN) nx = LAST_X; else off = 1'b1;
                  end else nx = x - 5'd1;
            default: if (x == LAST_X) begin
                      if (WRAP_EN) nx = 5'd0; else off = 1'b1;
                  end else nx = x + 5'd1;
        endcase
        return {off, nx, ny};
    endfunction

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_cur_dir, w_cur_dir_nxt;
    logic [1:0]    r_desired_dir, w_desired_dir_nxt;
    logic [1:0]    r_try_dir, w_try_dir_nxt;
    logic [4:0]    r_pos_x, w_pos_x_nxt;
    logic [4:0]    r_pos_y, w_pos_y_nxt;
    logic [4:0]    r_tile_x, w_tile_x_nxt;
    logic [4:0]    r_tile_y, w_tile_y_nxt;
    logic          r_tile_req, w_tile_req_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_moving, w_moving_nxt;
    logic          r_reg_en, w_reg_en_nxt;
    logic          r_reg_rw, w_reg_rw_nxt;
    logic [4:0]    r_reg_x, w_reg_x_nxt;
    logic [4:0]    r_reg_y, w_reg_y_nxt;
    logic          r_pellet, w_pellet_nxt;
    logic          r_power, w_power_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_busy, w_busy_nxt;

    logic [1:0]    w_des_now;
    logic [10:0]   w_step_a;
    logic [10:0]   w_step_b_idle;
    logic [10:0]   w_step_b_qry;
    logic          w_ack;
    logic          w_wall;

    // A dir_valid coincident with the tick takes effect for that tick.
    assign w_des_now     = dir_valid ? dir_code : r_desired_dir;
    assign w_step_a      = f_step(pac_x, pac_y, w_des_now);
    assign w_step_b_idle = f_step(pac_x, pac_y, r_cur_dir);
    assign w_step_b_qry  = f_step(r_pos_x, r_pos_y, r_cur_dir);
    // An ack only counts while a request is actually outstanding.
    assign w_ack         = r_tile_req & tile_ack;
    assign w_wall        = (tile_type == WALL_TYPE);

    // State and output registers.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cur_dir     <= 2'd3;
            r_desired_dir <= 2'd3;
            r_try_dir     <= 2'd3;
            r_pos_x       <= 5'd0;
            r_pos_y       <= 5'd0;
            r_tile_x      <= 5'd0;
            r_tile_y      <= 5'd0;
            r_tile_req    <= 1'b0;
            r_cnt         <= '0;
            r_moving      <= 1'b0;
            r_reg_en      <= 1'b0;
            r_reg_rw      <= 1'b1;
            r_reg_x       <= 5'd0;
            r_reg_y       <= 5'd0;
            r_pellet      <= 1'b0;
            r_power       <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_dir     <= w_cur_dir_nxt;
            r_desired_dir <= w_desired_dir_nxt;
            r_try_dir     <= w_try_dir_nxt;
            r_pos_x       <= w_pos_x_nxt;
            r_pos_y       <= w_pos_y_nxt;
            r_tile_x      <= w_tile_x_nxt;
            r_tile_y      <= w_tile_y_nxt;
            r_tile_req    <= w_tile_req_nxt;
            r_cnt         <= w_cnt_nxt;
            r_moving      <= w_moving_nxt;
            r_reg_en      <= w_reg_en_nxt;
            r_reg_rw      <= w_reg_rw_nxt;
            r_reg_x       <= w_reg_x_nxt;
            r_reg_y       <= w_reg_y_nxt;
            r_pellet      <= w_pellet_nxt;
            r_power       <= w_power_nxt;
            r_timeout     <= w_timeout_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_cur_dir_nxt     = r_cur_dir;
        w_desired_dir_nxt = dir_valid ? dir_code : r_desired_dir;
        w_try_dir_nxt     = r_try_dir;
        w_pos_x_nxt       = r_pos_x;
        w_pos_y_nxt       = r_pos_y;
        w_tile_x_nxt      = r_tile_x;
        w_tile_y_nxt      = r_tile_y;
        w_tile_req_nxt    = r_tile_req;
        w_cnt_nxt         = r_cnt;
        w_moving_nxt      = r_moving;
        w_reg_en_nxt      = 1'b0;
        w_reg_rw_nxt      = 1'b1;
        w_reg_x_nxt       = r_reg_x;
        w_reg_y_nxt       = r_reg_y;
        w_pellet_nxt      = 1'b0;
        w_power_nxt       = 1'b0;
        w_timeout_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (move_tick) begin
                    w_pos_x_nxt   = pac_x;
                    w_pos_y_nxt   = pac_y;
                    w_try_dir_nxt = w_des_now;
                    w_cnt_nxt     = '0;
                    if (!w_step_a[10]) begin
                        w_state_nxt    = S_QUERY_A;
                        w_tile_req_nxt = 1'b1;
                        w_tile_x_nxt   = w_step_a[9:5];
                        w_tile_y_nxt   = w_step_a[4:0];
                    end else if (w_des_now == r_cur_dir || w_step_b_idle[10]) begin
                        // Off-grid target behaves as a wall with nowhere to fall back.
                        w_moving_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = S_QUERY_B;
                        w_tile_req_nxt = 1'b1;
                        w_tile_x_nxt   = w_step_b_idle[9:5];
                        w_tile_y_nxt   = w_step_b_idle[4:0];
                    end
                end
            end

            S_QUERY_A: begin
                if (w_ack) begin
                    w_tile_req_nxt = 1'b0;
                    if (!w_wall) begin
                        w_cur_dir_nxt = r_try_dir;
                        w_state_nxt   = S_COMMIT;
                        w_reg_en_nxt  = 1'b1;
                        w_reg_rw_nxt  = 1'b0;
                        w_reg_x_nxt   = r_tile_x;
                        w_reg_y_nxt   = r_tile_y;
                        w_pellet_nxt  = (tile_type == PELLET_TYPE);
                        w_power_nxt   = (tile_type == POWER_TYPE);
                    end else if (r_try_dir == r_cur_dir || w_step_b_qry[10]) begin
                        w_moving_nxt = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        // Fallback query; the request is re-raised next cycle.
                        w_state_nxt  = S_QUERY_B;
                        w_tile_x_nxt = w_step_b_qry[9:5];
                        w_tile_y_nxt = w_step_b_qry[4:0];
                        w_cnt_nxt    = '0;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_tile_req_nxt = 1'b0;
                    w_timeout_nxt  = 1'b1;
                    w_moving_nxt   = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_QUERY_B: begin
                if (!r_tile_req) begin
                    w_tile_req_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                end else if (w_ack) begin
                    w_tile_req_nxt = 1'b0;
                    if (!w_wall) begin
                        w_state_nxt  = S_COMMIT;
                        w_reg_en_nxt = 1'b1;
                        w_reg_rw_nxt = 1'b0;
                        w_reg_x_nxt  = r_tile_x;
                        w_reg_y_nxt  = r_tile_y;
                        w_pellet_nxt = (tile_type == PELLET_TYPE);
                        w_power_nxt  = (tile_type == POWER_TYPE);
                    end else begin
                        w_moving_nxt = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_tile_req_nxt = 1'b0;
                    w_timeout_nxt  = 1'b1;
                    w_moving_nxt   = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_moving_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign reg_x_in      = r_reg_x;
    assign reg_y_in      = r_reg_y;
    assign reg_en        = r_reg_en;
    assign reg_readwrite = r_reg_rw;
    assign tile_req      = r_tile_req;
    assign tile_x        = r_tile_x;
    assign tile_y        = r_tile_y;
    assign pellet_eaten  = r_pellet;
    assign power_eaten   = r_power;
    assign tile_timeout  = r_timeout;
    assign busy          = r_busy;
    assign moving        = r_moving;
    assign cur_dir       = r_cur_dir;

endmodule

// File: tb/tb_pacman_move_controller.sv
// Directed bench for pacman_move_controller. The main instance wraps and times out
// after 4 cycles; a second instance has wrapping disabled. Expected commits go
// into a queue and are popped by a monitor whenever the main instance writes.
module tb_pacman_move_controller;

    localparam logic [2:0] WALL = 3'd1;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       pel;
        logic       pow;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_tick = 1'b0, dir_valid = 1'b0, tile_ack = 1'b0;
    logic [1:0] dir_code = 2'd0;
    logic [4:0] pac_x = 5'd0, pac_y = 5'd0;
    logic [2:0] tile_type = 3'd0;
    logic [4:0] reg_x_in, reg_y_in, tile_x, tile_y;
    logic       reg_en, reg_readwrite, tile_req, pellet_eaten, power_eaten;
    logic       tile_timeout, busy, moving;
    logic [1:0] cur_dir;

    logic       n_tick = 1'b0, n_dv = 1'b0, n_ack = 1'b0;
    logic [1:0] n_dir = 2'd0;
    logic [4:0] n_px = 5'd0, n_py = 5'd0;
    logic [2:0] n_type = 3'd0;
    logic [4:0] n_rx, n_ry, n_tx, n_ty;
    logic       n_en, n_rw, n_req, n_pel, n_pow, n_to, n_busy, n_mov;
    logic [1:0] n_cur;

    always #5 clk = ~clk;

    pacman_move_controller #(.WRAP_EN(1'b1), .ACK_TIMEOUT(4)) dut (
        .clock_50(clk), .reset_n(rst_n), .move_tick(move_tick), .dir_valid(dir_valid),
        .dir_code(dir_code), .pac_x(pac_x), .pac_y(pac_y), .reg_x_in(reg_x_in),
        .reg_y_in(reg_y_in), .reg_en(reg_en), .reg_readwrite(reg_readwrite),
        .tile_req(tile_req), .tile_x(tile_x), .tile_y(tile_y), .tile_ack(tile_ack),
        .tile_type(tile_type), .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
        .tile_timeout(tile_timeout), .busy(busy), .moving(moving), .cur_dir(cur_dir)
    );

    pacman_move_controller #(.WRAP_EN(1'b0)) dut_nw (
        .clock_50(clk), .reset_n(rst_n), .move_tick(n_tick), .dir_valid(n_dv),
        .dir_code(n_dir), .pac_x(n_px), .pac_y(n_py), .reg_x_in(n_rx),
        .reg_y_in(n_ry), .reg_en(n_en), .reg_readwrite(n_rw),
        .tile_req(n_req), .tile_x(n_tx), .tile_y(n_ty), .tile_ack(n_ack),
        .tile_type(n_type), .pellet_eaten(n_pel), .power_eaten(n_pow),
        .tile_timeout(n_to), .busy(n_busy), .moving(n_mov), .cur_dir(n_cur)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every commit of the main instance must match the oldest expectation.
    always @(negedge clk) begin
        if (reg_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 32'(reg_en), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_x", 32'(reg_x_in), 32'(e.x));
                chk("commit_y", 32'(reg_y_in), 32'(e.y));
                chk("commit_rw", 32'(reg_readwrite), 32'd0);
                chk("commit_pellet", 32'(pellet_eaten), 32'(e.pel));
                chk("commit_power", 32'(power_eaten), 32'(e.pow));
            end
        end
    end

    task automatic tick(input logic [4:0] x, input logic [4:0] y,
                        input logic dv, input logic [1:0] d);
        pac_x = x; pac_y = y; dir_valid = dv; dir_code = d; move_tick = 1'b1;
    endtask

    task automatic untick();
        move_tick = 1'b0; dir_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_req", 32'(tile_req), 32'd0);
        chk("rst_en", 32'(reg_en), 32'd0);
        chk("rst_rw", 32'(reg_readwrite), 32'd1);
        chk("rst_dir", 32'(cur_dir), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: straight move right, zero-wait ack
        tick(5'd5, 5'd5, 1'b1, 2'd3);
        exp_q.push_back('{x: 5'd6, y: 5'd5, pel: 1'b0, pow: 1'b0});
        cyc();
        untick(); tile_ack = 1'b1; tile_type = 3'd0;
        smp();
        chk("t1_req", 32'(tile_req), 32'd1);
        chk("t1_tx", 32'(tile_x), 32'd6);
        chk("t1_ty", 32'(tile_y), 32'd5);
        chk("t1_busy", 32'(busy), 32'd1);
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t1_commit_en", 32'(reg_en), 32'd1);
        chk("t1_req_after_ack", 32'(tile_req), 32'd0);
        cyc();
        smp();
        chk("t1_moving", 32'(moving), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_en_low", 32'(reg_en), 32'd0);

        // 2: up is a wall, fall back to right into a pellet
        cyc();
        tick(5'd5, 5'd5, 1'b1, 2'd0);
        exp_q.push_back('{x: 5'd6, y: 5'd5, pel: 1'b1, pow: 1'b0});
        cyc();
        untick(); tile_ack = 1'b1; tile_type = WALL;
        smp();
        chk("t2_qa_tx", 32'(tile_x), 32'd5);
        chk("t2_qa_ty", 32'(tile_y), 32'd4);
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t2_gap_req", 32'(tile_req), 32'd0);
        cyc();
        tile_ack = 1'b1; tile_type = 3'd2;
        smp();
        chk("t2_qb_req", 32'(tile_req), 32'd1);
        chk("t2_qb_tx", 32'(tile_x), 32'd6);
        chk("t2_qb_ty", 32'(tile_y), 32'd5);
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t2_commit_en", 32'(reg_en), 32'd1);
        chk("t2_dir", 32'(cur_dir), 32'd3);
        cyc();
        smp();
        chk("t2_pellet_once", 32'(pellet_eaten), 32'd0);

        // 3: both candidates are walls
        cyc();
        tick(5'd5, 5'd5, 1'b0, 2'd0);
        cyc();
        untick(); tile_ack = 1'b1; tile_type = WALL;
        cyc();
        tile_ack = 1'b0;
        cyc();
        tile_ack = 1'b1;
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_moving", 32'(moving), 32'd0);
        chk("t3_dir", 32'(cur_dir), 32'd3);

        // 4: wrap from x=0 going left into a power pellet
        cyc();
        tick(5'd0, 5'd10, 1'b1, 2'd2);
        exp_q.push_back('{x: 5'd20, y: 5'd10, pel: 1'b0, pow: 1'b1});
        cyc();
        untick(); tile_ack = 1'b1; tile_type = 3'd3;
        smp();
        chk("t4_tx", 32'(tile_x), 32'd20);
        chk("t4_ty", 32'(tile_y), 32'd10);
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t4_dir", 32'(cur_dir), 32'd2);
        cyc();

        // 4b: no-wrap instance; first turn it left, then push off the edge
        n_px = 5'd5; n_py = 5'd10; n_dv = 1'b1; n_dir = 2'd2; n_tick = 1'b1;
        cyc();
        n_tick = 1'b0; n_dv = 1'b0; n_ack = 1'b1; n_type = 3'd0;
        smp();
        chk("nw_tx", 32'(n_tx), 32'd4);
        cyc();
        n_ack = 1'b0;
        smp();
        chk("nw_commit_en", 32'(n_en), 32'd1);
        chk("nw_commit_x", 32'(n_rx), 32'd4);
        cyc();
        smp();
        chk("nw_moving1", 32'(n_mov), 32'd1);
        n_px = 5'd0; n_py = 5'd10; n_tick = 1'b1;
        cyc();
        n_tick = 1'b0;
        smp();
        chk("nw_edge_req", 32'(n_req), 32'd0);
        chk("nw_edge_busy", 32'(n_busy), 32'd0);
        chk("nw_edge_moving", 32'(n_mov), 32'd0);
        cyc();
        smp();
        chk("nw_edge_req2", 32'(n_req), 32'd0);

        // 5: ack never arrives
        cyc();
        tick(5'd3, 5'd3, 1'b1, 2'd3);
        cyc();
        untick();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("t5_req_%0d", i), 32'(tile_req), 32'd1);
            chk($sformatf("t5_to_%0d", i), 32'(tile_timeout), 32'd0);
            cyc();
        end
        smp();
        chk("t5_req_drop", 32'(tile_req), 32'd0);
        chk("t5_timeout", 32'(tile_timeout), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_moving", 32'(moving), 32'd0);
        chk("t5_dir_kept", 32'(cur_dir), 32'd2);
        cyc();
        tick(5'd3, 5'd3, 1'b0, 2'd0);
        exp_q.push_back('{x: 5'd4, y: 5'd3, pel: 1'b0, pow: 1'b0});
        smp();
        chk("t5_to_clear", 32'(tile_timeout), 32'd0);
        cyc();
        untick(); tile_ack = 1'b1; tile_type = 3'd0;
        cyc();
        tile_ack = 1'b0;
        smp();
        chk("t5_retry_dir", 32'(cur_dir), 32'd3);
        cyc();

        // 6a: asynchronous reset in the middle of a query
        tick(5'd7, 5'd7, 1'b1, 2'd2);
        cyc();
        untick();
        smp();
        chk("t6_req_before", 32'(tile_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_rst", 32'(tile_req), 32'd0);
        chk("t6_tx_rst", 32'(tile_x), 32'd0);
        chk("t6_rw_rst", 32'(reg_readwrite), 32'd1);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_moving_rst", 32'(moving), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 6b: a tick while busy is dropped
        tick(5'd7, 5'd7, 1'b0, 2'd0);
        exp_q.push_back('{x: 5'd8, y: 5'd7, pel: 1'b0, pow: 1'b0});
        cyc();
        tick(5'd1, 5'd1, 1'b0, 2'd0);
        cyc();
        untick(); tile_ack = 1'b1; tile_type = 3'd0;
        smp();
        chk("t6_tx_held", 32'(tile_x), 32'd8);
        cyc();
        tile_ack = 1'b0;
        cyc();
        smp();
        chk("t6_no_second_req", 32'(tile_req), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        cyc();
        smp();
        chk("t6_no_second_req2", 32'(tile_req), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
